// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha quarter-round coprocessors:
// rotation amounts, FSM encoding, operand packing and word helpers.
package chacha_pkg;

    localparam int unsigned ROT_16 = 16;
    localparam int unsigned ROT_12 = 12;
    localparam int unsigned ROT_8  = 8;
    localparam int unsigned ROT_7  = 7;

    localparam int WORD_W = 32;

    // Word positions inside the packed operands: rs1 = {a,d}, rs2 = {b,c}.
    localparam int IDX_A = 1;
    localparam int IDX_D = 0;
    localparam int IDX_B = 1;
    localparam int IDX_C = 0;

    localparam logic [2:0] STEP_LAST = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] rotr32(input logic [WORD_W-1:0] x,
                                                 input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] word_get(input logic [2*WORD_W-1:0] x,
                                                   input int idx);
        return x[idx*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/chacha_iqr_half.sv
// One inverse ChaCha half-step, selected by k; purely combinational.
// Words not touched by step k pass through unchanged.
module chacha_iqr_half
    import chacha_pkg::*;
(
    input  logic [1:0]        k,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] c,
    input  logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] a_nx,
    output logic [WORD_W-1:0] b_nx,
    output logic [WORD_W-1:0] c_nx,
    output logic [WORD_W-1:0] d_nx
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a variable unassigned, which would infer a latch.
        a_nx = a;
        b_nx = b;
        c_nx = c;
        d_nx = d;
        case (k)
            2'd0: begin
                b_nx = rotr32(b, ROT_7) ^ c;
                c_nx = c - d;
            end
            2'd1: begin
                d_nx = rotr32(d, ROT_8) ^ a;
                a_nx = a - b;
            end
            2'd2: begin
                b_nx = rotr32(b, ROT_12) ^ c;
                c_nx = c - d;
            end
            default: begin
                d_nx = rotr32(d, ROT_16) ^ a;
                a_nx = a - b;
            end
        endcase
    end

endmodule

// File: rtl/chacha_iqr_seq.sv
// Iterative inverse ChaCha quarter-round behind valid/ready handshakes.
// Applies STEPS_PER_CYCLE inverse half-steps per BUSY cycle.
module chacha_iqr_seq
    import chacha_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic                g_clk,
    input  logic                g_resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*WORD_W-1:0] in_rs1,
    input  logic [2*WORD_W-1:0] in_rs2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*WORD_W-1:0] out_rd1,
    output logic [2*WORD_W-1:0] out_rd2,
    output logic                busy
);

    if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2) begin : g_bad_steps
        $error("chacha_iqr_seq: STEPS_PER_CYCLE must be 1 or 2");
    end

    state_t            state;
    state_t            state_nx;
    logic [2:0]        step_cnt;
    logic [WORD_W-1:0] a_q;
    logic [WORD_W-1:0] b_q;
    logic [WORD_W-1:0] c_q;
    logic [WORD_W-1:0] d_q;
    logic              steps_done;

    logic [WORD_W-1:0] a_ch [STEPS_PER_CYCLE+1];
    logic [WORD_W-1:0] b_ch [STEPS_PER_CYCLE+1];
    logic [WORD_W-1:0] c_ch [STEPS_PER_CYCLE+1];
    logic [WORD_W-1:0] d_ch [STEPS_PER_CYCLE+1];

    assign a_ch[0] = a_q;
    assign b_ch[0] = b_q;
    assign c_ch[0] = c_q;
    assign d_ch[0] = d_q;

    // Step chain: stage gi applies half-step (step_cnt + gi) mod 4.
    for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
        localparam logic [1:0] K_OFF = 2'(gi);

        chacha_iqr_half u_half (
            .k    (step_cnt[1:0] + K_OFF),
            .a    (a_ch[gi]),
            .b    (b_ch[gi]),
            .c    (c_ch[gi]),
            .d    (d_ch[gi]),
            .a_nx (a_ch[gi+1]),
            .b_nx (b_ch[gi+1]),
            .c_nx (c_ch[gi+1]),
            .d_nx (d_ch[gi+1])
        );
    end

    assign steps_done = (step_cnt == STEP_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (in_valid)   state_nx = ST_BUSY;
            ST_BUSY: if (steps_done) state_nx = ST_DONE;
            ST_DONE: if (out_ready)  state_nx = ST_IDLE;
            default:                 state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            // NOTE: the data words are reset too, so the outputs read as zero
            // after reset and an aborted request leaves nothing behind.
            state    <= ST_IDLE;
            step_cnt <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update from the same pre-edge values.
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q      <= word_get(in_rs1, IDX_A);
                        d_q      <= word_get(in_rs1, IDX_D);
                        b_q      <= word_get(in_rs2, IDX_B);
                        c_q      <= word_get(in_rs2, IDX_C);
                        step_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    if (!steps_done) begin
                        a_q      <= a_ch[STEPS_PER_CYCLE];
                        b_q      <= b_ch[STEPS_PER_CYCLE];
                        c_q      <= c_ch[STEPS_PER_CYCLE];
                        d_q      <= d_ch[STEPS_PER_CYCLE];
                        step_cnt <= step_cnt + 3'(STEPS_PER_CYCLE);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_BUSY);
    assign out_valid = (state == ST_DONE);

    always_comb begin
        out_rd1 = '0;
        out_rd2 = '0;
        out_rd1[IDX_A*WORD_W +: WORD_W] = a_q;
        out_rd1[IDX_D*WORD_W +: WORD_W] = d_q;
        out_rd2[IDX_B*WORD_W +: WORD_W] = b_q;
        out_rd2[IDX_C*WORD_W +: WORD_W] = c_q;
    end

endmodule

// File: tb/tb_chacha_iqr_seq.sv
// Bench for chacha_iqr_seq: one instance per legal STEPS_PER_CYCLE,
// driven from the same stimulus and checked against a forward model.
module tb_chacha_iqr_seq;

    logic        g_clk    = 1'b0;
    logic        g_resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_rs1 = '0;
    logic [63:0] in_rs2 = '0;

    logic        in_ready_s1, out_valid_s1, busy_s1;
    logic [63:0] rd1_s1, rd2_s1;
    logic        in_ready_s2, out_valid_s2, busy_s2;
    logic [63:0] rd1_s2, rd2_s2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 g_clk = ~g_clk;

    chacha_iqr_seq #(.STEPS_PER_CYCLE(1)) u_dut1 (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .in_valid (in_valid),
        .in_ready (in_ready_s1),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .out_valid(out_valid_s1),
        .out_ready(out_ready),
        .out_rd1  (rd1_s1),
        .out_rd2  (rd2_s1),
        .busy     (busy_s1)
    );

    chacha_iqr_seq #(.STEPS_PER_CYCLE(2)) u_dut2 (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .in_valid (in_valid),
        .in_ready (in_ready_s2),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .out_valid(out_valid_s2),
        .out_ready(out_ready),
        .out_rd1  (rd1_s2),
        .out_rd2  (rd2_s2),
        .busy     (busy_s2)
    );

    typedef struct packed {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Forward quarter-round; returns {a,b,c,d}.
    function automatic logic [127:0] fwd_qr(input logic [31:0] a0, input logic [31:0] b0,
                                            input logic [31:0] c0, input logic [31:0] d0);
        logic [31:0] a, b, c, d;
        a = a0; b = b0; c = c0; d = d0;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Entered #1 after a rising edge; presents one request and waits for both results.
    task automatic start_wait(input logic [63:0] rs1, input logic [63:0] rs2,
                              output int lat1, output int lat2);
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        @(posedge g_clk); #1;
        in_valid = 1'b0;
        lat1 = 0;
        lat2 = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge g_clk); #1;
            if (out_valid_s1 && lat1 == 0) lat1 = cyc;
            if (out_valid_s2 && lat2 == 0) lat2 = cyc;
            if (lat1 != 0 && lat2 != 0) break;
        end
    endtask

    task automatic check_result(input string tag, input logic [63:0] exp1, input logic [63:0] exp2,
                                input int lat1, input int lat2);
        check({tag, " lat s1"}, 64'(lat1), 64'd5);
        check({tag, " lat s2"}, 64'(lat2), 64'd3);
        check({tag, " rd1 s1"}, rd1_s1, exp1);
        check({tag, " rd2 s1"}, rd2_s1, exp2);
        check({tag, " rd1 s2"}, rd1_s2, exp1);
        check({tag, " rd2 s2"}, rd2_s2, exp2);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge g_clk); #1;
        out_ready = 1'b0;
        check({tag, " in_ready after hs s1"}, 64'(in_ready_s1), 64'd1);
        check({tag, " in_ready after hs s2"}, 64'(in_ready_s2), 64'd1);
        check({tag, " out_valid after hs s1"}, 64'(out_valid_s1), 64'd0);
        check({tag, " out_valid after hs s2"}, 64'(out_valid_s2), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat1, lat2;
        logic [127:0] fw;
        logic [31:0]  wa, wb, wc, wd;
        logic [63:0]  hold1, hold2;

        vecs[0] = '{rs1: 64'hea2a92f4_5881c4bb, rs2: 64'hcb1cf8ce_4581472e,
                    exp1: 64'h11111111_01234567, exp2: 64'h01020304_9b8d6f43};
        vecs[1] = '{rs1: 64'h0, rs2: 64'h0, exp1: 64'h0, exp2: 64'h0};
        fw = fwd_qr(32'hdeadbeef, 32'h00000001, 32'hffffffff, 32'h80000000);
        vecs[2] = '{rs1: {fw[127:96], fw[31:0]}, rs2: {fw[95:64], fw[63:32]},
                    exp1: 64'hdeadbeef_80000000, exp2: 64'h00000001_ffffffff};
        fw = fwd_qr(32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574);
        vecs[3] = '{rs1: {fw[127:96], fw[31:0]}, rs2: {fw[95:64], fw[63:32]},
                    exp1: 64'h61707865_6b206574, exp2: 64'h3320646e_79622d32};

        // Reset state
        #12;
        check("reset in_ready s1", 64'(in_ready_s1), 64'd1);
        check("reset in_ready s2", 64'(in_ready_s2), 64'd1);
        check("reset out_valid s1", 64'(out_valid_s1), 64'd0);
        check("reset busy s2", 64'(busy_s2), 64'd0);
        check("reset rd1 s1", rd1_s1, 64'd0);
        check("reset rd2 s2", rd2_s2, 64'd0);
        g_resetn = 1'b1;
        @(posedge g_clk); #1;

        for (int i = 0; i < 4; i++) begin
            start_wait(vecs[i].rs1, vecs[i].rs2, lat1, lat2);
            check_result($sformatf("vec%0d", i), vecs[i].exp1, vecs[i].exp2, lat1, lat2);
            release_out($sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE while in_valid pulses with unrelated data.
        start_wait(vecs[0].rs1, vecs[0].rs2, lat1, lat2);
        check_result("bp", vecs[0].exp1, vecs[0].exp2, lat1, lat2);
        hold1 = rd1_s1;
        hold2 = rd2_s2;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_rs1   = {$urandom, $urandom};
            in_rs2   = {$urandom, $urandom};
            @(posedge g_clk); #1;
            check("bp hold rd1 s1", rd1_s1, hold1);
            check("bp hold rd2 s2", rd2_s2, hold2);
            check("bp in_ready s1", 64'(in_ready_s1), 64'd0);
            check("bp in_ready s2", 64'(in_ready_s2), 64'd0);
            check("bp out_valid s1", 64'(out_valid_s1), 64'd1);
        end
        in_valid = 1'b0;
        release_out("bp");
        @(posedge g_clk); #1;
        check("bp nothing queued s1", 64'(busy_s1), 64'd0);
        check("bp nothing queued s2", 64'(in_ready_s2), 64'd1);

        // Asynchronous reset while BUSY at step 2.
        in_valid = 1'b1;
        in_rs1   = vecs[0].rs1;
        in_rs2   = vecs[0].rs2;
        @(posedge g_clk); #1;
        in_valid = 1'b0;
        @(posedge g_clk); #1;
        @(posedge g_clk); #1;
        check("pre-reset busy s1", 64'(busy_s1), 64'd1);
        #2 g_resetn = 1'b0;
        #1;
        check("mid reset out_valid s1", 64'(out_valid_s1), 64'd0);
        check("mid reset in_ready s1", 64'(in_ready_s1), 64'd1);
        check("mid reset busy s1", 64'(busy_s1), 64'd0);
        check("mid reset in_ready s2", 64'(in_ready_s2), 64'd1);
        check("mid reset rd1 s1", rd1_s1, 64'd0);
        @(posedge g_clk); #1;
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
        check("post reset out_valid s1", 64'(out_valid_s1), 64'd0);
        start_wait(vecs[0].rs1, vecs[0].rs2, lat1, lat2);
        check_result("after reset", vecs[0].exp1, vecs[0].exp2, lat1, lat2);
        release_out("after reset");

        // Round trip through the forward model.
        for (int i = 0; i < 1000; i++) begin
            wa = $urandom; wb = $urandom; wc = $urandom; wd = $urandom;
            fw = fwd_qr(wa, wb, wc, wd);
            start_wait({fw[127:96], fw[31:0]}, {fw[95:64], fw[63:32]}, lat1, lat2);
            check_result($sformatf("rt%0d", i), {wa, wd}, {wb, wc}, lat1, lat2);
            release_out($sformatf("rt%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
